// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave that turns each AXI write/read into a
// single request on a simple word-addressed register port.
//   clk, rstn          : clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*    : AXI-Lite write address, write data, write response
//   s_ar*/s_r*         : AXI-Lite read address, read data
//   reg_wr_*           : register write request (word index), held until reg_wr_ack
//   reg_rd_*           : register read request (word index), held until reg_rd_ack;
//                        reg_rd_data is sampled one cycle after the ack
module axil_reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic                        reg_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data,
    input  logic                        reg_wr_ack,
    output logic                        reg_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_rd_addr,
    input  logic                        reg_rd_ack,
    input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data
);
    localparam int SW = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA, R_RESP} r_state_t;

    w_state_t                  w_state;
    r_state_t                  r_state;
    logic                      aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]             w_strb;

    logic                      aw_hs, w_hs, ar_hs, aw_now, w_now;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_now;
    logic [AXI_DATA_WIDTH-1:0] w_data_now;
    logic [SW-1:0]             w_strb_now;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;
    // "now" views merge this cycle's handshake with what is already held,
    // so the request can be issued on the edge the second channel arrives.
    assign aw_now      = aw_held || aw_hs;
    assign w_now       = w_held || w_hs;
    assign aw_addr_now = aw_hs ? s_awaddr : aw_addr;
    assign w_data_now  = w_hs ? s_wdata : w_data;
    assign w_strb_now  = w_hs ? s_wstrb : w_strb;
    assign s_rresp     = 2'b00;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bvalid    <= 1'b0;
            s_bresp     <= 2'b00;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_addr <= s_awaddr;
                    end
                    if (w_hs) begin
                        w_held <= 1'b1;
                        w_data <= s_wdata;
                        w_strb <= s_wstrb;
                    end
                    s_awready <= !aw_now;
                    s_wready  <= !w_now;
                    if (aw_now && w_now) begin
                        w_state     <= W_REQ;
                        // partial-strobe writes never reach the register port
                        reg_wr_en   <= &w_strb_now;
                        reg_wr_addr <= aw_addr_now >> 2;
                        reg_wr_data <= w_data_now;
                    end
                end
                W_REQ: begin
                    if (!(&w_strb) || reg_wr_ack) begin
                        w_state   <= W_RESP;
                        reg_wr_en <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= (&w_strb) ? 2'b00 : 2'b10;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        w_state   <= W_IDLE;
                        s_bvalid  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= R_IDLE;
            s_arready   <= 1'b0;
            s_rvalid    <= 1'b0;
            s_rdata     <= '0;
            reg_rd_en   <= 1'b0;
            reg_rd_addr <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_arready <= !ar_hs;
                    if (ar_hs) begin
                        r_state     <= R_REQ;
                        reg_rd_en   <= 1'b1;
                        reg_rd_addr <= s_araddr >> 2;
                    end
                end
                R_REQ: begin
                    if (reg_rd_ack) begin
                        r_state   <= R_DATA;
                        reg_rd_en <= 1'b0;
                    end
                end
                R_DATA: begin
                    r_state  <= R_RESP;
                    s_rdata  <= reg_rd_data;
                    s_rvalid <= 1'b1;
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_state   <= R_IDLE;
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: directed bench for axil_reg_bridge with a protocol-level
// model checked every cycle plus literal expectations per scenario.
module tb_axil_reg_bridge;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic        reg_wr_en;
    logic [31:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr_ack = 1'b1;
    logic        reg_rd_en;
    logic [31:0] reg_rd_addr;
    logic        reg_rd_ack = 1'b1;
    logic [31:0] reg_rd_data = 32'hBAD0BAD0;

    always #5 clk = ~clk;

    axil_reg_bridge dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_ack(reg_wr_ack),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_ack(reg_rd_ack),
        .reg_rd_data(reg_rd_data)
    );

    int n_cmp = 0, n_fail = 0;
    int n_wr = 0, n_rd = 0, n_b = 0, n_r = 0;
    logic [31:0] rd_val = '0;
    bit rsp_hit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // register-side responder: read data appears one cycle after an accepted request
    initial forever begin
        @(negedge clk);
        rsp_hit = reg_rd_en && reg_rd_ack;
        @(posedge clk);
        #1;
        reg_rd_data = rsp_hit ? rd_val : 32'hBAD0BAD0;
    end

    // Protocol model: which channels have been accepted, whether the register
    // request is outstanding, and whether a response is owed.
    bit live = 0;
    bit m_aw = 0, m_w = 0, m_wreq = 0, m_bv = 0;
    bit m_ar = 0, m_rreq = 0, m_cap = 0, m_rv = 0;
    logic [31:0] m_waddr = '0, m_wdata = '0, m_raddr = '0, m_rdata = '0;
    logic [3:0]  m_strb = '0;

    always @(negedge clk) begin
        if (!live) begin
            chk("rst_awready", s_awready, 0);
            chk("rst_wready", s_wready, 0);
            chk("rst_arready", s_arready, 0);
            chk("rst_bvalid", s_bvalid, 0);
            chk("rst_bresp", s_bresp, 0);
            chk("rst_rvalid", s_rvalid, 0);
            chk("rst_rdata", s_rdata, 0);
            chk("rst_wr_en", reg_wr_en, 0);
            chk("rst_rd_en", reg_rd_en, 0);
        end else begin
            chk("m_awready", s_awready, !m_aw);
            chk("m_wready", s_wready, !m_w);
            chk("m_arready", s_arready, !m_ar);
            chk("m_wr_en", reg_wr_en, m_wreq && (m_strb == 4'hF));
            if (m_wreq && m_strb == 4'hF) begin
                chk("m_wr_addr", reg_wr_addr, m_waddr / 4);
                chk("m_wr_data", reg_wr_data, m_wdata);
            end
            chk("m_bvalid", s_bvalid, m_bv);
            if (m_bv) chk("m_bresp", s_bresp, (m_strb == 4'hF) ? 0 : 2);
            chk("m_rd_en", reg_rd_en, m_rreq);
            if (m_rreq) chk("m_rd_addr", reg_rd_addr, m_raddr / 4);
            chk("m_rvalid", s_rvalid, m_rv);
            if (m_rv) chk("m_rdata", s_rdata, m_rdata);
            chk("m_rresp", s_rresp, 0);
        end
        n_wr += int'(reg_wr_en);
        n_rd += int'(reg_rd_en);
        n_b  += int'(s_bvalid && s_bready);
        n_r  += int'(s_rvalid && s_rready);
        if (!rstn) begin
            {live, m_aw, m_w, m_wreq, m_bv, m_ar, m_rreq, m_cap, m_rv} = '0;
        end else begin
            if (live) begin
                if (m_bv) begin
                    if (s_bready) {m_aw, m_w, m_bv} = '0;
                end else if (m_wreq) begin
                    if (m_strb != 4'hF || reg_wr_ack) begin
                        m_wreq = 0;
                        m_bv = 1;
                    end
                end else begin
                    if (s_awvalid && !m_aw) begin
                        m_aw = 1;
                        m_waddr = s_awaddr;
                    end
                    if (s_wvalid && !m_w) begin
                        m_w = 1;
                        m_wdata = s_wdata;
                        m_strb = s_wstrb;
                    end
                    if (m_aw && m_w) m_wreq = 1;
                end
                if (m_rv) begin
                    if (s_rready) {m_ar, m_rv} = '0;
                end else if (m_cap) begin
                    m_rdata = reg_rd_data;
                    m_cap = 0;
                    m_rv = 1;
                end else if (m_rreq) begin
                    if (reg_rd_ack) begin
                        m_rreq = 0;
                        m_cap = 1;
                    end
                end else if (s_arvalid && !m_ar) begin
                    m_ar = 1;
                    m_raddr = s_araddr;
                    m_rreq = 1;
                end
            end
            live = 1;
        end
    end

    int bw, br, bb, bq;

    initial begin
        repeat (3) step();
        chk("reset_awready", s_awready, 0);
        chk("reset_arready", s_arready, 0);
        chk("reset_rdata", s_rdata, 0);
        rstn = 1;
        step();
        chk("release_awready", s_awready, 1);
        chk("release_wready", s_wready, 1);
        chk("release_arready", s_arready, 1);

        // same-cycle AW+W, acks high
        bw = n_wr;
        s_awaddr = 32'h40; s_awvalid = 1;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
        step();
        s_awvalid = 0; s_wvalid = 0;
        chk("t1_wr_en", reg_wr_en, 1);
        chk("t1_wr_addr", reg_wr_addr, 32'h10);
        chk("t1_wr_data", reg_wr_data, 32'hDEADBEEF);
        chk("t1_awready", s_awready, 0);
        step();
        chk("t1_bvalid", s_bvalid, 1);
        chk("t1_bresp", s_bresp, 0);
        chk("t1_wr_en_off", reg_wr_en, 0);
        step();
        chk("t1_bvalid_off", s_bvalid, 0);
        chk("t1_awready_back", s_awready, 1);
        chk("t1_wr_count", n_wr - bw, 1);

        // W three cycles ahead of AW
        bw = n_wr;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1;
        step();
        s_wvalid = 0;
        chk("t2_wready_low", s_wready, 0);
        chk("t2_awready", s_awready, 1);
        repeat (2) begin
            chk("t2_no_wr_en", reg_wr_en, 0);
            step();
        end
        s_awaddr = 32'h44; s_awvalid = 1;
        chk("t2_no_wr_en", reg_wr_en, 0);
        step();
        s_awvalid = 0;
        chk("t2_wr_en", reg_wr_en, 1);
        chk("t2_wr_addr", reg_wr_addr, 32'h11);
        chk("t2_wr_data", reg_wr_data, 32'h12345678);
        step();
        chk("t2_bvalid", s_bvalid, 1);
        chk("t2_bresp", s_bresp, 0);
        step();
        chk("t2_wr_count", n_wr - bw, 1);

        // partial strobe -> SLVERR, no register write
        bw = n_wr;
        s_awaddr = 32'h48; s_awvalid = 1;
        s_wdata = 32'h11111111; s_wstrb = 4'h3; s_wvalid = 1;
        step();
        s_awvalid = 0; s_wvalid = 0;
        chk("t3_no_wr_en", reg_wr_en, 0);
        step();
        chk("t3_bvalid", s_bvalid, 1);
        chk("t3_bresp", s_bresp, 2);
        step();
        chk("t3_wr_count", n_wr - bw, 0);

        // read with rready stalled
        br = n_rd;
        rd_val = 32'h5; s_rready = 0;
        s_araddr = 32'h8; s_arvalid = 1;
        step();
        s_arvalid = 0;
        chk("t4_rd_en", reg_rd_en, 1);
        chk("t4_rd_addr", reg_rd_addr, 32'h2);
        chk("t4_arready", s_arready, 0);
        step();
        chk("t4_rd_en_off", reg_rd_en, 0);
        chk("t4_rvalid_early", s_rvalid, 0);
        step();
        repeat (4) begin
            chk("t4_rvalid_hold", s_rvalid, 1);
            chk("t4_rdata_hold", s_rdata, 32'h5);
            chk("t4_arready_hold", s_arready, 0);
            step();
        end
        s_rready = 1;
        chk("t4_rvalid_last", s_rvalid, 1);
        step();
        chk("t4_rvalid_off", s_rvalid, 0);
        chk("t4_arready_back", s_arready, 1);
        chk("t4_rd_count", n_rd - br, 1);

        // simultaneous read+write with acks held off three cycles
        bw = n_wr; br = n_rd; bb = n_b; bq = n_r;
        reg_wr_ack = 0; reg_rd_ack = 0; rd_val = 32'hA5A50001;
        s_awaddr = 32'h80; s_awvalid = 1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1;
        s_araddr = 32'hC; s_arvalid = 1;
        step();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        repeat (3) begin
            chk("t5_wr_en_hold", reg_wr_en, 1);
            chk("t5_rd_en_hold", reg_rd_en, 1);
            step();
        end
        reg_wr_ack = 1; reg_rd_ack = 1;
        chk("t5_wr_en_ack", reg_wr_en, 1);
        chk("t5_rd_en_ack", reg_rd_en, 1);
        step();
        chk("t5_wr_en_off", reg_wr_en, 0);
        chk("t5_rd_en_off", reg_rd_en, 0);
        chk("t5_bvalid", s_bvalid, 1);
        chk("t5_bresp", s_bresp, 0);
        step();
        chk("t5_rvalid", s_rvalid, 1);
        chk("t5_rdata", s_rdata, 32'hA5A50001);
        repeat (3) step();
        chk("t5_wr_count", n_wr - bw, 4);
        chk("t5_rd_count", n_rd - br, 4);
        chk("t5_b_count", n_b - bb, 1);
        chk("t5_r_count", n_r - bq, 1);

        // reset while the write request is outstanding
        reg_wr_ack = 0;
        s_awaddr = 32'h50; s_awvalid = 1;
        s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
        step();
        s_awvalid = 0; s_wvalid = 0;
        chk("t6_wr_en", reg_wr_en, 1);
        rstn = 0;
        step();
        chk("t6_rst_wr_en", reg_wr_en, 0);
        chk("t6_rst_bvalid", s_bvalid, 0);
        chk("t6_rst_awready", s_awready, 0);
        rstn = 1; reg_wr_ack = 1;
        bw = n_wr; bb = n_b;
        step();
        chk("t6_awready", s_awready, 1);
        chk("t6_wready", s_wready, 1);
        chk("t6_arready", s_arready, 1);
        repeat (4) begin
            chk("t6_no_bvalid", s_bvalid, 0);
            chk("t6_no_wr_en", reg_wr_en, 0);
            step();
        end
        chk("t6_wr_count", n_wr - bw, 0);
        chk("t6_b_count", n_b - bb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI-Lite byte address width and reg port address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI-Lite data width and reg port data width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have AXI-Lite write-address ports s_awaddr in AXI_ADDR_WIDTH, s_awvalid in 1, s_awready out 1.
REQ-006 SHALL have write-data ports s_wdata in AXI_DATA_WIDTH, s_wstrb in AXI_DATA_WIDTH/8, s_wvalid in 1, s_wready out 1.
REQ-007 SHALL have write-response ports s_bresp out 2, s_bvalid out 1, s_bready in 1.
REQ-008 SHALL have read-address ports s_araddr in AXI_ADDR_WIDTH, s_arvalid in 1, s_arready out 1.
REQ-009 SHALL have read-data ports s_rdata out AXI_DATA_WIDTH, s_rresp out 2, s_rvalid out 1, s_rready in 1.
REQ-010 SHALL have reg write ports reg_wr_en out 1, reg_wr_addr out AXI_ADDR_WIDTH (word index), reg_wr_data out AXI_DATA_WIDTH, reg_wr_ack in 1.
REQ-011 SHALL have reg read ports reg_rd_en out 1, reg_rd_addr out AXI_ADDR_WIDTH (word index), reg_rd_ack in 1, reg_rd_data in AXI_DATA_WIDTH (valid 1 cycle after accepted request).

Function
REQ-012 Write and read paths SHALL be independent FSMs; both may issue reg requests in the same cycle.
REQ-013 Write FSM states SHALL be W_IDLE, W_REQ, W_RESP.
REQ-014 W_IDLE: s_awready = !aw_held, s_wready = !w_held; each handshake latches addr/data+strb and sets its held flag; AW and W accepted in any order or same cycle.
REQ-015 W_IDLE -> W_REQ at clock edge where both held flags are (or become) set.
REQ-016 W_REQ: reg_wr_en=1, reg_wr_addr = latched awaddr >> 2, reg_wr_data = latched wdata; held until reg_wr_ack=1 in same cycle, then -> W_RESP.
REQ-017 If latched wstrb != all ones: W_REQ SHALL NOT assert reg_wr_en, goes directly to W_RESP with s_bresp=2'b10 (SLVERR); otherwise s_bresp=2'b00.
REQ-018 W_RESP: s_bvalid=1 until s_bready=1; then clear held flags, -> W_IDLE; s_awready/s_wready = 0 outside W_IDLE.
REQ-019 Read FSM states SHALL be R_IDLE, R_REQ, R_DATA, R_RESP.
REQ-020 R_IDLE: s_arready=1; on handshake latch araddr, -> R_REQ.
REQ-021 R_REQ: reg_rd_en=1, reg_rd_addr = latched araddr >> 2; on reg_rd_ack=1 -> R_DATA.
REQ-022 R_DATA: capture reg_rd_data into s_rdata register, -> R_RESP; s_rresp=2'b00 always.
REQ-023 R_RESP: s_rvalid=1, s_rdata stable until s_rready=1, then -> R_IDLE.
REQ-024 Latency with acks tied high: AW&W handshake cycle T -> reg_wr_en at T+1 -> s_bvalid at T+2; AR handshake T -> reg_rd_en T+1 -> s_rvalid T+3.
REQ-025 reg_wr_en and reg_rd_en SHALL each be high for exactly one cycle per AXI transaction when ack is tied high; address low 2 bits ignored.
REQ-026 Throughput: one outstanding write and one outstanding read max; new AW/W/AR not accepted until previous response handshake completes.
REQ-027 s_bvalid/s_rvalid SHALL NOT depend combinationally on s_bready/s_rready; payload stable while valid && !ready.

Reset
REQ-028 While rstn=0: both FSMs to IDLE, held flags cleared, all outputs 0 (including s_awready, s_wready, s_arready, s_bresp, s_rdata).
REQ-029 Readies SHALL rise in the first cycle after rstn=1 sampled; rstn=0 mid-transaction SHALL abort it with no reg_wr_en/reg_rd_en and no response afterwards.

Verification
REQ-030 AW (addr 0x40) and W (0xDEADBEEF, strb 0xF) same cycle, acks high -> one reg_wr_en, reg_wr_addr=0x10, data 0xDEADBEEF, then bvalid bresp=00.
REQ-031 W three cycles before AW (addr 0x44) -> no reg_wr_en until AW accepted; then reg_wr_addr=0x11; wready low after W accepted.
REQ-032 Write strb 0x3 -> no reg_wr_en, bresp=10.
REQ-033 AR addr 0x8, reg_rd_data=0x5 on cycle after rd_en, rready held low 4 cycles -> rvalid stays high, rdata=0x5 stable, arready low until rready.
REQ-034 reg_wr_ack/reg_rd_ack held low 3 cycles -> reg_*_en held high 4 cycles, single completion; simultaneous read+write complete independently.
REQ-035 rstn=0 one cycle while in W_REQ -> no bvalid, FSMs idle, readies high next cycle after release.
